// File: rtl/fir_filter_param.sv
// Multi-channel time-multiplexed FIR: one MAC per tap per cycle, shared coefficient set.
// Define FIR_SATURATE_EN to clamp out-of-range results and flag out_sat; otherwise results wrap.
module fir_filter_param #(
  parameter int DATA_W     = 24,
  parameter int COEF_W     = 24,
  parameter int TAPS       = 32,
  parameter int CHANNELS   = 3,
  parameter int FRAC_SHIFT = 23
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  input  logic                         coef_we,
  input  logic [$clog2(TAPS)-1:0]      coef_addr,
  input  logic [COEF_W-1:0]            coef_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic [CHANNELS-1:0]          out_sat
);

  localparam int AW    = $clog2(TAPS);
  localparam int ACC_W = DATA_W + COEF_W + AW;
  localparam int RND_W = ACC_W + 1;
  localparam int HSH   = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
  localparam logic signed [RND_W-1:0] HALF =
    (FRAC_SHIFT > 0) ? (RND_W'(1) << HSH) : '0;

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  state_e                     r_state, w_state_nxt;
  logic [AW-1:0]              r_k;
  logic signed [DATA_W-1:0]   r_x   [CHANNELS][TAPS];
  logic signed [COEF_W-1:0]   r_h   [TAPS];
  logic signed [ACC_W-1:0]    r_acc [CHANNELS];
  logic signed [ACC_W-1:0]    w_prod [CHANNELS];
  logic signed [RND_W-1:0]    w_rnd  [CHANNELS];
  logic                       w_accept;
  logic                       w_last_tap;

  assign w_accept   = in_valid && (r_state == StIdle);
  assign w_last_tap = (r_k == AW'(TAPS - 1));

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = StMac;
      end
      StMac: begin
        if (w_last_tap) w_state_nxt = StOut;
      end
      StOut: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_k <= '0;
      end else if (r_state == StMac) begin
        r_k <= w_last_tap ? '0 : r_k + AW'(1);
      end
    end
  end

  // Coefficients are frozen outside IDLE so a pass always sees one consistent set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < TAPS; t++) r_h[t] <= '0;
    end else if (coef_we && (r_state == StIdle) && (32'(coef_addr) < TAPS)) begin
      r_h[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int t = 0; t < TAPS; t++) r_x[c][t] <= '0;
      end
    end else if (w_accept) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int t = TAPS - 1; t > 0; t--) r_x[c][t] <= r_x[c][t-1];
        r_x[c][0] <= in_data[c*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_prod[c] = ACC_W'(r_x[c][r_k]) * ACC_W'(r_h[r_k]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) r_acc[c] <= '0;
    end else if (w_accept) begin
      for (int c = 0; c < CHANNELS; c++) r_acc[c] <= '0;
    end else if (r_state == StMac) begin
      for (int c = 0; c < CHANNELS; c++) r_acc[c] <= r_acc[c] + w_prod[c];
    end
  end

  // The accumulator is stable in OUT, so the output stays steady under backpressure.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_rnd[c] = RND_W'(r_acc[c]) + HALF;
    end
  end

`ifdef FIR_SATURATE_EN
  localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [RND_W-1:0] w_shf [CHANNELS];
  logic [CHANNELS-1:0]     w_ovf;

  always_comb begin
    out_data = '0;
    out_sat  = '0;
    w_ovf    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_shf[c] = w_rnd[c] >>> FRAC_SHIFT;
      // In range only when every bit above the DATA_W sign bit matches it.
      w_ovf[c] = (w_shf[c][RND_W-1:DATA_W-1] != '0) && (w_shf[c][RND_W-1:DATA_W-1] != '1);
      if (w_ovf[c]) begin
        out_data[c*DATA_W +: DATA_W] = w_shf[c][RND_W-1] ? SMIN : SMAX;
        out_sat[c]                   = 1'b1;
      end else begin
        out_data[c*DATA_W +: DATA_W] = w_shf[c][DATA_W-1:0];
      end
    end
  end
`else
  always_comb begin
    out_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      out_data[c*DATA_W +: DATA_W] = DATA_W'(w_rnd[c] >>> FRAC_SHIFT);
    end
  end

  assign out_sat = '0;
`endif

endmodule

// File: tb/tb_fir_filter_param.sv
// Scoreboard bench: a 3-channel FRAC_SHIFT=0 instance and a 1-channel FRAC_SHIFT=1 instance.
module tb_fir_filter_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        coef_we = 1'b0;
  logic        out_ready = 1'b1;
  logic        dsel = 1'b0;
  logic [71:0] in_data = '0;
  logic [1:0]  coef_addr = '0;
  logic [23:0] coef_data = '0;

  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [71:0] out_data0;
  logic [2:0]  out_sat0;
  logic [23:0] out_data1;
  logic [0:0]  out_sat1;

  int          n_vec = 0;
  int          n_miss = 0;
  logic [71:0] q0_d[$];
  logic [2:0]  q0_s[$];
  logic [23:0] q1_d[$];
  logic [71:0] m0_d;
  logic [2:0]  m0_s;
  logic [23:0] m1_d;

  always #5 clk = ~clk;

  fir_filter_param #(
    .DATA_W(24), .COEF_W(24), .TAPS(4), .CHANNELS(3), .FRAC_SHIFT(0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid & ~dsel), .in_ready(in_ready0),
    .in_data(in_data), .coef_we(coef_we & ~dsel), .coef_addr(coef_addr),
    .coef_data(coef_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_sat(out_sat0)
  );

  fir_filter_param #(
    .DATA_W(24), .COEF_W(24), .TAPS(4), .CHANNELS(1), .FRAC_SHIFT(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid & dsel), .in_ready(in_ready1),
    .in_data(in_data[23:0]), .coef_we(coef_we & dsel), .coef_addr(coef_addr),
    .coef_data(coef_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_sat(out_sat1)
  );

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] p3(input int a, input int b, input int c);
    return {c[23:0], b[23:0], a[23:0]};
  endfunction

  task automatic push0(input logic [71:0] d, input logic [2:0] s);
    q0_d.push_back(d);
    q0_s.push_back(s);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid0 && out_ready) begin
      if (q0_d.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_out0: got %0h expected none", out_data0);
      end else begin
        m0_d = q0_d.pop_front();
        m0_s = q0_s.pop_front();
        check("out0_data", out_data0, m0_d);
        check("out0_sat", 72'(out_sat0), 72'(m0_s));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid1 && out_ready) begin
      if (q1_d.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_out1: got %0h expected none", out_data1);
      end else begin
        m1_d = q1_d.pop_front();
        check("out1_data", 72'(out_data1), 72'(m1_d));
        check("out1_sat", 72'(out_sat1), 72'(1'b0));
      end
    end
  end

  task automatic send(input logic sel, input logic [71:0] d, input logic cwe,
                      input logic [1:0] ca, input logic [23:0] cd);
    int t = 0;
    dsel = sel;
    @(negedge clk);
    while (!(sel ? in_ready1 : in_ready0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_vec++;
      n_miss++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    in_valid  = 1'b1;
    in_data   = d;
    coef_we   = cwe;
    coef_addr = ca;
    coef_data = cd;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
  endtask

  task automatic wcoef(input logic sel, input logic [1:0] a, input int v);
    dsel = sel;
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = v[23:0];
    @(posedge clk);
    #1;
    coef_we = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q0_d.size() != 0 || q1_d.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q0_d.size() + q1_d.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Backpressure: result must hold, input side must stay closed, stray in_valid ignored.
  task automatic stall(input logic [71:0] exp);
    int t = 0;
    while (!out_valid0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("stall_reach_out", 72'(out_valid0), 72'(1'b1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", 72'(out_valid0), 72'(1'b1));
      check("stall_in_ready", 72'(in_ready0), 72'(1'b0));
      check("stall_data", out_data0, exp);
      if (i == 3) begin
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = p3(999, 999, 999);
      end
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0[5] = '{1, 0, 0, 0, 0};
    int e0[5] = '{1, 2, 3, 4, 0};
    int e1[5] = '{5, 15, 30, 50, 50};
    int e2[5] = '{-3, -9, -18, -30, -30};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 72'(in_ready0), 72'(1'b1));
    check("rst_out_valid", 72'(out_valid0), 72'(1'b0));
    check("rst_out_data", out_data0, '0);
    check("rst_out_sat", 72'(out_sat0), '0);

    for (int i = 0; i < 4; i++) wcoef(1'b0, 2'(i), i + 1);

    // ch0 impulse, ch1 constant 5, ch2 constant -3
    for (int i = 0; i < 5; i++) begin
      push0(p3(e0[i], e1[i], e2[i]), 3'b000);
      send(1'b0, p3(a0[i], 5, -3), 1'b0, 2'd0, 24'd0);
      if (i == 2) begin
        out_ready = 1'b0;
        stall(p3(3, 30, -18));
      end
    end
    drain();

    // Boundary: 2 * full-scale
    wcoef(1'b0, 2'd0, 2);
    for (int i = 1; i < 4; i++) wcoef(1'b0, 2'(i), 0);
`ifdef FIR_SATURATE_EN
    push0(p3(8388607, -8388608, 200), 3'b011);
`else
    push0(p3(-2, 0, 200), 3'b000);
`endif
    send(1'b0, p3(8388607, -8388608, 100), 1'b0, 2'd0, 24'd0);
    drain();

    // Reset during the second MAC cycle kills the in-flight result
    for (int i = 0; i < 4; i++) wcoef(1'b0, 2'(i), i + 1);
    send(1'b0, p3(7, 0, 0), 1'b0, 2'd0, 24'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_mid_no_valid", 72'(out_valid0), 72'(1'b0));
    end
    check("rst_mid_out_data", out_data0, '0);
    check("rst_mid_in_ready", 72'(in_ready0), 72'(1'b1));
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) wcoef(1'b0, 2'(i), i + 1);
    for (int i = 0; i < 4; i++) begin
      push0(p3(e0[i], 0, 0), 3'b000);
      send(1'b0, p3(a0[i], 0, 0), 1'b0, 2'd0, 24'd0);
    end
    drain();

    // FRAC_SHIFT=1 instance; h[0] written in the same cycle as the first sample
    q1_d.push_back(24'd2);
    send(1'b1, p3(3, 0, 0), 1'b1, 2'd0, 24'd1);
    q1_d.push_back(24'hFFFFFF);
    send(1'b1, p3(-3, 0, 0), 1'b0, 2'd0, 24'd0);
    q1_d.push_back(24'd3);
    send(1'b1, p3(5, 0, 0), 1'b0, 2'd0, 24'd0);
    @(negedge clk);
    check("mac_in_ready", 72'(in_ready1), 72'(1'b0));
    coef_we   = 1'b1;
    coef_addr = 2'd0;
    coef_data = 24'd3;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    q1_d.push_back(24'd2);
    send(1'b1, p3(4, 0, 0), 1'b0, 2'd0, 24'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
